// File: rtl/siggen_pkg.sv
// Shared definitions for the signal-generator trigger sequencer:
// FSM state encoding and host control-wire bit positions.
package siggen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HIGH = 3'd1,
        ST_LOW  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Bit positions inside the 32-bit host control wire
    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

endpackage

// File: rtl/phase_timer.sv
// Reusable phase timer: load restarts the count, count advances while
// enabled, expire flags the last cycle of a phase of length lim (lim >= 1).
// The count saturates at lim-1 and never wraps.
module phase_timer #(
    parameter int W = 32
) (
    input  logic         clki,
    input  logic         rstn,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] lim,
    output logic         expire
);

    logic [W-1:0] cnt;

    assign expire = en && (cnt == (lim - W'(1)));

    // Phase cycle counter: cleared on load, held once the phase has expired
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/siggen_trig_sequencer.sv
// Trigger sequencer for the signal generator: on a host start edge it
// latches the configuration and emits bursts of square trigger pulses
// separated by gaps, reporting completion or abort with one-cycle pulses.
module siggen_trig_sequencer
    import siggen_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int NUM_W = 16
) (
    input  logic             clki,
    input  logic             rstn,
    input  logic [31:0]      ep_ctrl,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [NUM_W-1:0] cfg_pulses,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [NUM_W-1:0] cfg_bursts,
    output logic             trig_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [NUM_W-1:0] pulse_cnt,
    output logic [NUM_W-1:0] burst_cnt
);

    typedef struct packed {
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] gap;
        logic [NUM_W-1:0] pulses;
        logic [NUM_W-1:0] bursts;
    } shadow_t;

    state_t     state, state_nxt;
    shadow_t    shd;

    logic       start_lvl, abort_lvl;
    logic       start_prev, start_arm;
    logic       start_ev, abort_ev, go, zero_run;
    logic       tmr_en, tmr_load, tmr_expire;
    logic [CNT_W-1:0] tmr_lim;
    logic       pulse_inc, burst_inc, pulse_clr;
    logic [NUM_W-1:0] pulse_nxt, burst_nxt;
    logic [29:0] unused_ctrl;

    assign start_lvl   = ep_ctrl[CTRL_START];
    assign abort_lvl   = ep_ctrl[CTRL_ABORT];
    assign unused_ctrl = ep_ctrl[31:2];

    // start_arm stays low after reset until the start bit has been seen low,
    // so a level held through reset cannot launch a run.
    assign start_ev = start_lvl && !start_prev && start_arm && !abort_lvl;
    assign abort_ev = abort_lvl && (state != ST_IDLE);
    assign go       = start_ev && (state == ST_IDLE);
    assign zero_run = (cfg_pulses == '0) || (cfg_bursts == '0);

    assign pulse_nxt = pulse_cnt + NUM_W'(1);
    assign burst_nxt = burst_cnt + NUM_W'(1);

    // One timer serves all timed phases; every phase exit is an expire,
    // so reloading on expire restarts it for the following phase.
    assign tmr_en   = (state == ST_HIGH) || (state == ST_LOW) || (state == ST_GAP);
    assign tmr_load = !tmr_en || tmr_expire || abort_ev;
    assign tmr_lim  = (state == ST_GAP) ? shd.gap : shd.half;

    phase_timer #(.W(CNT_W)) u_timer (
        .clki   (clki),
        .rstn   (rstn),
        .load   (tmr_load),
        .en     (tmr_en),
        .lim    (tmr_lim),
        .expire (tmr_expire)
    );

    // Start-edge detector and post-reset arming
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            start_prev <= 1'b0;
            start_arm  <= 1'b0;
        end else begin
            start_prev <= start_lvl;
            if (!start_lvl) start_arm <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and counter-update decode; abort overrides everything
    always_comb begin
        state_nxt = state;
        pulse_inc = 1'b0;
        burst_inc = 1'b0;
        pulse_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) state_nxt = zero_run ? ST_DONE : ST_HIGH;
            end
            ST_HIGH: begin
                if (tmr_expire) state_nxt = ST_LOW;
            end
            ST_LOW: begin
                if (tmr_expire) begin
                    pulse_inc = 1'b1;
                    if (pulse_nxt != shd.pulses) begin
                        state_nxt = ST_HIGH;
                    end else begin
                        burst_inc = 1'b1;
                        if (burst_nxt == shd.bursts) begin
                            state_nxt = ST_DONE;
                        end else if (shd.gap != '0) begin
                            state_nxt = ST_GAP;
                        end else begin
                            state_nxt = ST_HIGH;
                            pulse_clr = 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    state_nxt = ST_HIGH;
                    pulse_clr = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort_ev) begin
            state_nxt = ST_IDLE;
            pulse_inc = 1'b0;
            burst_inc = 1'b0;
            pulse_clr = 1'b0;
        end
    end

    // Shadow configuration, captured only on an accepted start
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            shd <= '0;
        end else if (go) begin
            shd.half   <= (cfg_half == '0) ? CNT_W'(1) : cfg_half;
            shd.gap    <= cfg_gap;
            shd.pulses <= cfg_pulses;
            shd.bursts <= cfg_bursts;
        end
    end

    // Pulse and burst progress counters; they hold after DONE or abort
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            pulse_cnt <= '0;
            burst_cnt <= '0;
        end else if (go) begin
            pulse_cnt <= '0;
            burst_cnt <= '0;
        end else begin
            if (pulse_clr)      pulse_cnt <= '0;
            else if (pulse_inc) pulse_cnt <= pulse_nxt;
            if (burst_inc)      burst_cnt <= burst_nxt;
        end
    end

    // Registered trigger and abort strobe, decoded from the next state
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            trig_out <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            trig_out <= (state_nxt == ST_HIGH);
            aborted  <= abort_ev;
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_siggen_trig_sequencer.sv
// Bench for siggen_trig_sequencer: each scenario pushes the expected
// per-cycle {trig_out, busy, done, aborted} into a queue when it drives the
// start, and a negedge monitor pops and compares one entry per cycle.
module tb_siggen_trig_sequencer;

    localparam int CNT_W = 32;
    localparam int NUM_W = 16;

    logic             clki = 1'b0;
    logic             rstn = 1'b0;
    logic [31:0]      ep_ctrl = '0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic [NUM_W-1:0] cfg_pulses = '0;
    logic [CNT_W-1:0] cfg_gap = '0;
    logic [NUM_W-1:0] cfg_bursts = '0;
    logic             trig_out, busy, done, aborted;
    logic [NUM_W-1:0] pulse_cnt, burst_cnt;

    // expected entry bits: {trig_out, busy, done, aborted}
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp, mon_act;
    int         n_cmp = 0;
    int         n_bad = 0;

    siggen_trig_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clki       (clki),
        .rstn       (rstn),
        .ep_ctrl    (ep_ctrl),
        .cfg_half   (cfg_half),
        .cfg_pulses (cfg_pulses),
        .cfg_gap    (cfg_gap),
        .cfg_bursts (cfg_bursts),
        .trig_out   (trig_out),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .pulse_cnt  (pulse_cnt),
        .burst_cnt  (burst_cnt)
    );

    always #5 clki = ~clki;

    // scoreboard monitor: one expected entry consumed per cycle
    always @(negedge clki) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {trig_out, busy, done, aborted};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_bad++;
                $display("FAIL seq_cycle t=%0t trig/busy/done/aborted got %b want %b",
                         $time, mon_act, mon_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic set_cfg(input int h, input int p, input int b, input int g);
        cfg_half   = CNT_W'(h);
        cfg_pulses = NUM_W'(p);
        cfg_bursts = NUM_W'(b);
        cfg_gap    = CNT_W'(g);
    endtask

    // raise start for cycle 0, return just after the cycle-0 negedge
    task automatic kick();
        @(posedge clki); #1;
        ep_ctrl[0] = 1'b1;
        @(negedge clki); #1;
    endtask

    // independent model of the expected waveform from cycle 1 onward
    task automatic push_run(input int h, input int p, input int b, input int g);
        int he;
        he = (h == 0) ? 1 : h;
        if (p == 0 || b == 0) begin
            exp_q.push_back(4'b0110);
            exp_q.push_back(4'b0000);
            return;
        end
        for (int bi = 0; bi < b; bi++) begin
            for (int pi = 0; pi < p; pi++) begin
                for (int k = 0; k < he; k++) exp_q.push_back(4'b1100);
                for (int k = 0; k < he; k++) exp_q.push_back(4'b0100);
            end
            if (bi < b - 1)
                for (int k = 0; k < g; k++) exp_q.push_back(4'b0100);
        end
        exp_q.push_back(4'b0110);
        exp_q.push_back(4'b0000);
    endtask

    task automatic start_run(input int h, input int p, input int b, input int g);
        set_cfg(h, p, b, g);
        kick();
        push_run(h, p, b, g);
    endtask

    // wait for the scoreboard to empty; an expired budget counts as a failure
    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clki);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout left %0d entries want 0", exp_q.size());
            exp_q.delete();
        end
        #1;
        ep_ctrl = '0;
        @(posedge clki); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clki);
        @(negedge clki);
        n_cmp++;
        if ({trig_out, busy, done, aborted} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags got %b want 0000", {trig_out, busy, done, aborted});
        end
        n_cmp++;
        if (pulse_cnt !== '0 || burst_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_counts got %0d/%0d want 0/0", pulse_cnt, burst_cnt);
        end
        @(posedge clki); #1;
        rstn = 1'b1;
        @(posedge clki); #1;
    endtask

    task automatic test_basic();
        start_run(2, 3, 1, 0);
        wait_drain(60);
        n_cmp++;
        if (pulse_cnt !== 16'd3 || burst_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL basic_counts got %0d/%0d want 3/1", pulse_cnt, burst_cnt);
        end
    endtask

    task automatic test_multi_burst();
        start_run(1, 2, 2, 3);
        wait_drain(60);
        n_cmp++;
        if (pulse_cnt !== 16'd2 || burst_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL multi_counts got %0d/%0d want 2/2", pulse_cnt, burst_cnt);
        end
        start_run(1, 1, 3, 0);
        wait_drain(60);
        n_cmp++;
        if (pulse_cnt !== 16'd1 || burst_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL nogap_counts got %0d/%0d want 1/3", pulse_cnt, burst_cnt);
        end
    endtask

    task automatic test_half_zero();
        start_run(0, 2, 1, 5);
        wait_drain(40);
    endtask

    task automatic test_zero_pulses();
        start_run(3, 0, 2, 1);
        wait_drain(20);
        n_cmp++;
        if (pulse_cnt !== '0 || burst_cnt !== '0) begin
            n_bad++;
            $display("FAIL zero_counts got %0d/%0d want 0/0", pulse_cnt, burst_cnt);
        end
        start_run(3, 2, 0, 1);
        wait_drain(20);
    endtask

    task automatic test_abort();
        set_cfg(2, 3, 1, 0);
        kick();
        exp_q.push_back(4'b1100); exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1100); exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0001);
        repeat (4) exp_q.push_back(4'b0000);
        repeat (6) @(posedge clki);
        #1 ep_ctrl[1] = 1'b1;
        @(posedge clki); #1;
        ep_ctrl[1] = 1'b0;
        wait_drain(40);
        // start edge coinciding with abort is discarded, and start held
        // afterwards is not a new edge
        ep_ctrl = 32'h3;
        repeat (4) exp_q.push_back(4'b0000);
        @(posedge clki); #1;
        ep_ctrl = 32'h1;
        wait_drain(20);
    endtask

    task automatic test_busy_start();
        start_run(1, 2, 1, 0);
        @(posedge clki); #1;
        ep_ctrl[0] = 1'b0;
        cfg_pulses = 16'd5;
        cfg_half   = 32'd7;
        @(posedge clki); #1;
        ep_ctrl[0] = 1'b1;
        wait_drain(40);
        n_cmp++;
        if (pulse_cnt !== 16'd2 || burst_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL busy_counts got %0d/%0d want 2/1", pulse_cnt, burst_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        set_cfg(4, 2, 1, 0);
        kick();
        exp_q.push_back(4'b1100);
        @(posedge clki);
        @(posedge clki); #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (trig_out !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset trig/busy got %b%b want 00", trig_out, busy);
        end
        repeat (2) @(posedge clki);
        #1 rstn = 1'b1;
        repeat (5) exp_q.push_back(4'b0000);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clki);
        n_cmp++;
        if (exp_q.size() != 0 || pulse_cnt !== '0) begin
            n_bad++;
            $display("FAIL held_start_after_reset left %0d pulse_cnt %0d want 0/0",
                     exp_q.size(), pulse_cnt);
            exp_q.delete();
        end
        #1 ep_ctrl[0] = 1'b0;
        start_run(4, 2, 1, 0);
        wait_drain(60);
    endtask

    task automatic test_back_to_back();
        int h, p, b, g;
        for (int it = 0; it < 5; it++) begin
            h = int'($urandom_range(0, 3));
            p = int'($urandom_range(0, 3));
            b = int'($urandom_range(1, 3));
            g = int'($urandom_range(0, 2));
            start_run(h, p, b, g);
            wait_drain(200);
            n_cmp++;
            if (pulse_cnt !== NUM_W'(p) || burst_cnt !== NUM_W'((p == 0) ? 0 : b)) begin
                n_bad++;
                $display("FAIL rand_counts h=%0d p=%0d b=%0d g=%0d got %0d/%0d want %0d/%0d",
                         h, p, b, g, pulse_cnt, burst_cnt, p, (p == 0) ? 0 : b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_burst();
        test_half_zero();
        test_zero_pulses();
        test_abort();
        test_busy_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
